uart_cmd_frame_decoder: RTL
===========================

Name: uart_cmd_frame_decoder

Overview:
Front end of the BRAM memory-management path. It receives bytes from the UART receiver and parses framed host commands (sync, command, start address, end address, checksum), then validates each frame. A valid frame is presented to the memory processor as command/start_address/end_address with a valid/ack handshake. Every frame gets an ACK or NAK byte back to the host through the UART transmitter.

Parameters:
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles once a frame has started (must be >=2)
SYNC_BYTE, 8'hA5, frame start marker
CMD_READ, 8'h01, legal read opcode
CMD_WRITE, 8'h02, legal write opcode
ACK_BYTE, 8'h06, response for an accepted frame
NAK_BYTE, 8'h15, response for a rejected frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  received byte, valid while rx_done=1
rx_done  in  1  level: UART receiver holds a byte
rx_trigger  out  1  one-cycle pulse: byte consumed, receiver may re-arm
tx_done  in  1  level: UART transmitter idle
tx_byte  out  8  response byte to transmit
tx_trigger  out  1  one-cycle pulse: start transmitting tx_byte
command  out  8  decoded opcode (01 or 02)
start_address  out  16  decoded first address
end_address  out  16  decoded last address, inclusive
cmd_valid  out  1  decoded command is available
cmd_ack  in  1  processor accepted the command
err_count  out  8  saturating count of rejected or timed-out frames

Behaviour:
- Reset: the asynchronous assertion of rst_n clears all outputs and state immediately. All outputs reset to 0. The state machine goes to IDLE, the byte counter and timeout counter clear, and the rx_armed flag sets to 1. A reset mid-frame or mid-handshake discards everything.
- Byte acceptance:
  - A byte is taken on a cycle where rx_done=1, rx_armed=1, and the state is IDLE or COLLECT.
  - On the next cycle rx_trigger=1 for exactly one cycle, and rx_armed clears.
  - rx_armed sets again only after rx_done is sampled 0. One rx_done assertion therefore yields one byte.
  - In CHECK, RESP and ISSUE, no bytes are consumed (backpressure) and rx_trigger stays 0.
- IDLE:
  - Accepted byte equal to SYNC_BYTE: go to COLLECT, clear byte counter and checksum.
  - Any other byte: consumed and dropped, with no error.
- COLLECT:
  - Takes 6 bytes in order: cmd, sa_hi, sa_lo, ea_hi, ea_lo, chk.
  - The running XOR covers the first 5 bytes and is compared with chk.
  - After the 6th byte, go to CHECK.
  - The timeout counter resets on each accepted byte and increments otherwise. When it reaches TIMEOUT_CYCLES: go to IDLE, increment err_count, send no response.
  - A SYNC_BYTE value inside COLLECT is treated as data.
- CHECK (1 cycle): the frame is valid only if all of these hold:
  - cmd is CMD_READ or CMD_WRITE;
  - {sa_hi,sa_lo} <= {ea_hi,ea_lo}, compared unsigned 16-bit;
  - the XOR matches chk.
  - Valid: latch command, start_address and end_address; go to RESP with ACK_BYTE.
  - Invalid: go to RESP with NAK_BYTE, increment err_count, leave the command outputs unchanged.
- RESP:
  - Wait for tx_done=1, then drive tx_byte and pulse tx_trigger=1 for one cycle.
  - tx_byte holds its value until the next response.
  - After an ACK go to ISSUE; after a NAK go to IDLE.
- ISSUE:
  - cmd_valid=1, with command, start_address and end_address stable.
  - The cycle cmd_ack=1 is sampled, cmd_valid drops on the next cycle and the state goes to IDLE.
  - cmd_ack outside ISSUE is ignored.
- err_count saturates at 8'hFF and never wraps.
- Simultaneous events:
  - A timeout and a byte acceptance in the same cycle: the byte wins and the counter resets.
  - rx_done held high across states never produces more than one acceptance.
- Latency: from the 6th byte acceptance, CHECK takes 1 cycle. The tx_trigger pulse follows at the earliest 2 cycles later, if tx_done=1. cmd_valid rises the cycle after tx_trigger.

Test Plan:
1. Valid read frame A5 01 00 10 00 1F 0E, with rx_done pulsed and dropped per byte -> exactly 7 rx_trigger pulses; tx_trigger with tx_byte=06; cmd_valid=1 with command=01, start_address=0010, end_address=001F, held across 20 idle cycles; cmd_ack pulse -> cmd_valid=0 next cycle; err_count=0.
2. Bad checksum A5 02 00 00 00 05 00 -> tx_byte=15 pulse; cmd_valid never asserts; err_count=1; a following valid write frame A5 02 00 00 00 05 07 is accepted with ACK.
3. Rejected frames:
   - start>end: A5 02 00 20 00 10 32 -> NAK, err_count increments.
   - opcode 03: A5 03 00 00 00 00 03 -> NAK.
4. Garbage 00 FF 5A before A5 01 12 34 12 34 01 -> garbage consumed silently; ACK; start_address = end_address = 1234.
5. TIMEOUT_CYCLES=100: send A5 01 00, then stall 100 cycles -> back to IDLE, err_count=1, no tx_trigger; the next valid frame is accepted. Hold tx_done=0 during RESP for 50 cycles -> tx_trigger waits, then fires once.
6. Reset cases:
   - rst_n low mid-COLLECT and during ISSUE -> all outputs 0 immediately, without a clock edge; the next frame is decoded normally.
   - 256 bad frames -> err_count=FF.

Source files
------------

// File: rtl/uart_cmd_frame_decoder.sv
// UART host command frame decoder: sync/cmd/addr/addr/xor framing,
// ACK/NAK response and valid/ack hand-off to the memory processor.
module uart_cmd_frame_decoder #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] CMD_READ       = 8'h01,
    parameter logic [7:0] CMD_WRITE      = 8'h02,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic        rx_trigger,
    input  logic        tx_done,
    output logic [7:0]  tx_byte,
    output logic        tx_trigger,
    output logic [7:0]  command,
    output logic [15:0] start_address,
    output logic [15:0] end_address,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        RESP,
        ISSUE
    } state_t;

    state_t        state;
    logic          rx_armed;
    logic [2:0]    byte_cnt;
    logic [7:0]    xsum;
    logic [7:0]    f_cmd;
    logic [7:0]    f_chk;
    logic [15:0]   f_sa;
    logic [15:0]   f_ea;
    logic [TW-1:0] tmo;
    logic          resp_ack;
    logic          accept;
    logic          frame_ok;

    assign accept = rx_done && rx_armed
                    && (state == IDLE || state == COLLECT);

    assign frame_ok = (f_cmd == CMD_READ || f_cmd == CMD_WRITE)
                      && (f_sa <= f_ea)
                      && (xsum == f_chk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rx_armed      <= 1'b1;
            byte_cnt      <= '0;
            xsum          <= '0;
            f_cmd         <= '0;
            f_chk         <= '0;
            f_sa          <= '0;
            f_ea          <= '0;
            tmo           <= '0;
            resp_ack      <= 1'b0;
            rx_trigger    <= 1'b0;
            tx_byte       <= '0;
            tx_trigger    <= 1'b0;
            command       <= '0;
            start_address <= '0;
            end_address   <= '0;
            cmd_valid     <= 1'b0;
            err_count     <= '0;
        end else begin
            rx_trigger <= accept;
            tx_trigger <= 1'b0;
            // re-arm only once the receiver has dropped its byte
            if (accept)
                rx_armed <= 1'b0;
            else if (!rx_done)
                rx_armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept && rx_byte == SYNC_BYTE) begin
                        state    <= COLLECT;
                        byte_cnt <= '0;
                        xsum     <= '0;
                        tmo      <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        tmo      <= '0;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt != 3'd5)
                            xsum <= xsum ^ rx_byte;
                        case (byte_cnt)
                            3'd0: f_cmd      <= rx_byte;
                            3'd1: f_sa[15:8] <= rx_byte;
                            3'd2: f_sa[7:0]  <= rx_byte;
                            3'd3: f_ea[15:8] <= rx_byte;
                            3'd4: f_ea[7:0]  <= rx_byte;
                            default: begin
                                f_chk <= rx_byte;
                                state <= CHECK;
                            end
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        state <= IDLE;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                CHECK: begin
                    resp_ack <= frame_ok;
                    state    <= RESP;
                    if (frame_ok) begin
                        command       <= f_cmd;
                        start_address <= f_sa;
                        end_address   <= f_ea;
                    end else if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                RESP: begin
                    if (tx_done) begin
                        tx_byte    <= resp_ack ? ACK_BYTE : NAK_BYTE;
                        tx_trigger <= 1'b1;
                        state      <= resp_ack ? ISSUE : IDLE;
                    end
                end
                ISSUE: begin
                    if (cmd_valid && cmd_ack) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
